// File: rtl/pc_fetch_unit_pkg.sv
// Shared PIC16C5x core definitions: fetch phases, execute states, stack
// commands and fetch-stage constants.
package pc_fetch_unit_pkg;

  localparam int FE_STATE_BITS    = 2;
  localparam int EX_STATE_BITS    = 4;
  localparam int PC_WIDTH_DEFAULT = 11;
  localparam int PC_FULL_WIDTH    = 11;

  localparam logic [11:0] INST_NOP = 12'h000;

  typedef enum logic [FE_STATE_BITS-1:0] {
    FE_Q1 = 2'd0,
    FE_Q2 = 2'd1,
    FE_Q3 = 2'd2,
    FE_Q4 = 2'd3
  } feState_t;

  typedef enum logic [EX_STATE_BITS-1:0] {
    EX_Q1        = 4'd0,
    EX_Q2        = 4'd1,
    EX_Q3        = 4'd2,
    EX_Q4_NOP    = 4'd3,
    EX_Q4_ALU    = 4'd4,
    EX_Q4_MOVWF  = 4'd5,
    EX_Q4_CLRF   = 4'd6,
    EX_Q4_FSZ    = 4'd7,
    EX_Q4_BTFSX  = 4'd8,
    EX_Q4_BXF    = 4'd9,
    EX_Q4_MOVLW  = 4'd10,
    EX_Q4_CALL   = 4'd11,
    EX_Q4_GOTO   = 4'd12,
    EX_Q4_RETLW  = 4'd13,
    EX_Q4_OPTION = 4'd14,
    EX_Q4_TRIS   = 4'd15
  } exState_t;

  typedef enum logic [1:0] {
    STK_NOP  = 2'd0,
    STK_PUSH = 2'd1,
    STK_POP  = 2'd2
  } stkCmd_t;

  // True for the execute states whose fetched word must be replaced by NOP
  // regardless of the datapath qualifiers.
  function automatic logic isBranchState(input exState_t st);
    logic result;
    case (st)
      EX_Q4_RETLW, EX_Q4_GOTO, EX_Q4_CALL: result = 1'b1;
      default:                             result = 1'b0;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/pc_fetch_unit_call_stack.sv
// call_stack: two-entry hardware return stack; a third push silently drops
// the oldest entry and a pop never flags underflow.
module call_stack
  import pc_fetch_unit_pkg::*;
#(
  parameter int WIDTH = PC_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  stkCmd_t          command,
  input  logic [WIDTH-1:0] dataIn,
  output logic [WIDTH-1:0] tos
);

  logic [WIDTH-1:0] entry0_r;
  logic [WIDTH-1:0] entry1_r;
  logic [WIDTH-1:0] entry0Nxt_s;
  logic [WIDTH-1:0] entry1Nxt_s;

  // Next-entry selection for push/pop; pop leaves the bottom entry in place.
  always_comb begin
    entry0Nxt_s = entry0_r;
    entry1Nxt_s = entry1_r;
    if (enable) begin
      case (command)
        STK_PUSH: begin
          entry0Nxt_s = dataIn;
          entry1Nxt_s = entry0_r;
        end
        STK_POP: begin
          entry0Nxt_s = entry1_r;
          entry1Nxt_s = entry1_r;
        end
        default: begin
          entry0Nxt_s = entry0_r;
          entry1Nxt_s = entry1_r;
        end
      endcase
    end else begin
      entry0Nxt_s = entry0_r;
      entry1Nxt_s = entry1_r;
    end
  end

  // Stack entry registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      entry0_r <= {WIDTH{1'b0}};
      entry1_r <= {WIDTH{1'b0}};
    end else begin
      entry0_r <= entry0Nxt_s;
      entry1_r <= entry1Nxt_s;
    end
  end

  assign tos = entry0_r;

endmodule

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: PIC16C5x program counter, instruction register and next-PC
// selection. Everything advances on the edge that ends the Q4 fetch phase.
module pc_fetch_unit
  import pc_fetch_unit_pkg::*;
#(
  parameter int                  PC_WIDTH     = PC_WIDTH_DEFAULT,
  parameter logic [PC_WIDTH-1:0] RESET_VECTOR = {PC_WIDTH{1'b1}}
) (
  input  logic                clk,
  input  logic                rst_n,
  input  feState_t            fetchState,
  input  exState_t            executeState,
  input  stkCmd_t             stackCommand,
  input  logic                skip,
  input  logic [1:0]          pageBits,
  input  logic                pclWrite,
  input  logic [7:0]          pclData,
  input  logic [11:0]         romData,
  output logic [PC_WIDTH-1:0] romAddr,
  output logic [11:0]         instOut,
  output logic [7:0]          pclOut
);

  logic [PC_WIDTH-1:0]      pc_r;
  logic [11:0]              inst_r;
  logic [PC_WIDTH-1:0]      pcNxt_s;
  logic [11:0]              instNxt_s;
  logic [PC_WIDTH-1:0]      pcInc_s;
  logic [PC_WIDTH-1:0]      tos_s;
  logic                     updateEdge_s;
  logic                     discard_s;
  logic [PC_FULL_WIDTH-1:0] gotoFull_s;
  logic [PC_FULL_WIDTH-1:0] callFull_s;
  logic [PC_FULL_WIDTH-1:0] pclFull_s;

  assign updateEdge_s = (fetchState == FE_Q4);
  assign pcInc_s      = pc_r + {{(PC_WIDTH-1){1'b0}}, 1'b1};

  // Targets are formed at full 11-bit width, then truncated for smaller parts.
  assign gotoFull_s = {pageBits, inst_r[8:0]};
  assign callFull_s = {pageBits, 1'b0, inst_r[7:0]};
  assign pclFull_s  = {pageBits, 1'b0, pclData};

  // Next-PC priority: return, goto, call, PCL write, then sequential.
  always_comb begin
    pcNxt_s = pcInc_s;
    case (executeState)
      EX_Q4_RETLW: pcNxt_s = tos_s;
      EX_Q4_GOTO:  pcNxt_s = gotoFull_s[PC_WIDTH-1:0];
      EX_Q4_CALL:  pcNxt_s = callFull_s[PC_WIDTH-1:0];
      default: begin
        if (pclWrite) begin
          pcNxt_s = pclFull_s[PC_WIDTH-1:0];
        end else begin
          pcNxt_s = pcInc_s;
        end
      end
    endcase
  end

  // The prefetched word is squashed whenever control flow leaves PC+1 or a
  // skip is taken; a taken skip still advances the PC by one.
  always_comb begin
    discard_s = 1'b0;
    case (executeState)
      EX_Q4_FSZ, EX_Q4_BTFSX: discard_s = skip | pclWrite;
      default: begin
        if (isBranchState(executeState)) begin
          discard_s = 1'b1;
        end else begin
          discard_s = pclWrite;
        end
      end
    endcase
  end

  assign instNxt_s = discard_s ? INST_NOP : romData;

  // PC and IR registers, loaded only on the Q4 update edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_r   <= RESET_VECTOR;
      inst_r <= INST_NOP;
    end else if (updateEdge_s) begin
      pc_r   <= pcNxt_s;
      inst_r <= instNxt_s;
    end else begin
      pc_r   <= pc_r;
      inst_r <= inst_r;
    end
  end

  // The PC before the update already points past the call: it is the return address.
  call_stack #(
    .WIDTH (PC_WIDTH)
  ) uCallStack (
    .clk     (clk),
    .rst_n   (rst_n),
    .enable  (updateEdge_s),
    .command (stackCommand),
    .dataIn  (pc_r),
    .tos     (tos_s)
  );

  assign romAddr = pc_r;
  assign instOut = inst_r;
  assign pclOut  = pc_r[7:0];

endmodule
